// File: rtl/palette_pkg.sv
// Shared types, defaults and helpers for the palette_mp palette memory.
package palette_pkg;

  localparam int PAL_ADDR_W = 5;
  localparam int PAL_DATA_W = 6;

  // Grayscale keeps the luma bits [DATA_W-1:4] and clears the hue bits [3:0].
  localparam logic [PAL_DATA_W-1:0] GRAY_MASK = {{(PAL_DATA_W-4){1'b1}}, 4'b0000};

  typedef enum logic {INIT, RUN} pal_state_t;

  // Backdrop mirroring: entries whose low two bits are zero alias into the lower half.
  function automatic logic [31:0] pal_mirror(input logic [31:0] addr,
                                             input int unsigned aw,
                                             input logic        en);
    logic [31:0] m;
    m = addr;
    if (en && (addr[1:0] == 2'b00)) m[aw-1] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/palette_mp_clear_seq.sv
// Post-reset clear sweep: walks every raw palette index once and holds busy
// until the final entry has been written.
module palette_clear_seq
  import palette_pkg::*;
#(
  parameter int ADDR_W = PAL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  pal_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // Sweep FSM: INIT counts through DEPTH entries, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign sweep_we   = busy;
  assign sweep_addr = cnt;

endmodule

// File: rtl/palette_mp.sv
// Dual-port PPU palette memory: CPU read/write port with 1-cycle read valid,
// render lookup port with grayscale masking, backdrop mirroring and
// write-first forwarding. Optional post-reset clear sweep under PAL_CLEAR_EN.
module palette_mp
  import palette_pkg::*;
#(
  parameter int                DATA_W    = PAL_DATA_W,
  parameter int                ADDR_W    = PAL_ADDR_W,
  parameter int                MIRROR_BG = 1,
  parameter string             PAL_INIT  = "",
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_rvalid,
  input  logic              ren_en,
  input  logic [ADDR_W-1:0] ren_addr,
  input  logic              gray,
  output logic [DATA_W-1:0] ren_data_o,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] GMASK = {{(DATA_W-4){1'b1}}, 4'b0000};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] m_cpu, m_ren;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] cpu_rd_val, ren_raw, ren_val;

  assign m_cpu = ADDR_W'(pal_mirror(32'(cpu_addr), ADDR_W, MIRROR_BG != 0));
  assign m_ren = ADDR_W'(pal_mirror(32'(ren_addr), ADDR_W, MIRROR_BG != 0));

`ifdef PAL_CLEAR_EN
  palette_clear_seq #(.ADDR_W(ADDR_W)) u_clear (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );
`else
  assign busy       = 1'b0;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
`endif

  // Write-port mux: the clear sweep owns the port while busy, CPU writes are dropped.
  always_comb begin
    we    = cpu_wr;
    waddr = m_cpu;
    wdata = cpu_data_i;
    if (busy) begin
      we    = sweep_we;
      waddr = sweep_addr;
      wdata = INIT_VAL;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-data selection: zero while sweeping, otherwise write-first forwarding.
  always_comb begin
    cpu_rd_val = cpu_wr ? cpu_data_i : mem[m_cpu];
    ren_raw    = (cpu_wr && (m_cpu == m_ren)) ? cpu_data_i : mem[m_ren];
    if (busy) begin
      cpu_rd_val = '0;
      ren_raw    = '0;
    end
    ren_val = gray ? (ren_raw & GMASK) : ren_raw;
  end

  // Registered CPU read response and render colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_o <= '0;
      cpu_rvalid <= 1'b0;
      ren_data_o <= '0;
    end else begin
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_data_o <= cpu_rd_val;
      if (ren_en) ren_data_o <= ren_val;
    end
  end

endmodule

// File: tb/tb_palette_mp.sv
// Scoreboard bench for palette_mp: the driver pushes the expected response of
// every cycle; a monitor pops one entry per cycle and compares.
module tb_palette_mp;

  localparam int INIT_V = 'h0F;
`ifdef PAL_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cpu_addr = '0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [5:0] cpu_data_i = '0;
  logic [5:0] cpu_data_o;
  logic       cpu_rvalid;
  logic       ren_en = 1'b0;
  logic [4:0] ren_addr = '0;
  logic       gray = 1'b0;
  logic [5:0] ren_data_o;
  logic       busy;

  palette_mp #(.INIT_VAL(6'h0F)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_rvalid (cpu_rvalid),
    .ren_en     (ren_en),
    .ren_addr   (ren_addr),
    .gray       (gray),
    .ren_data_o (ren_data_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cv;
    int cd;
    int rd;
    int bz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  int mem_m[32];
  int exp_cd = 0;
  int exp_rd = 0;
  int left = 0;

  function automatic int mir(input int a);
    return (a % 4 == 0) ? a % 16 : a;
  endfunction

  function automatic void chk(input string nm, input logic [7:0] act, input int exp);
    checks++;
    if (act !== 8'(exp)) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // One stimulus cycle: drive inputs, compute the expected outputs, push them.
  task automatic drive(input bit r, input bit wr, input bit rd, input int ca, input int cd,
                       input bit re, input int ra, input bit g);
    exp_t e;
    int ma, mr, v;
    @(negedge clk);
    rst = r; cpu_wr = wr; cpu_rd = rd; cpu_addr = 5'(ca); cpu_data_i = 6'(cd);
    ren_en = re; ren_addr = 5'(ra); gray = g;
    if (r) begin
      exp_cd = 0; exp_rd = 0;
      left = CLEAR ? 32 : 0;
      e.cv = 0; e.bz = CLEAR ? 1 : 0;
    end else if (left > 0) begin
      if (rd) exp_cd = 0;
      if (re) exp_rd = 0;
      left--;
      if (left == 0) foreach (mem_m[i]) mem_m[i] = INIT_V;
      e.cv = rd; e.bz = (left > 0) ? 1 : 0;
    end else begin
      ma = mir(ca); mr = mir(ra);
      if (rd) exp_cd = wr ? cd : mem_m[ma];
      if (re) begin
        v = (wr && ma == mr) ? cd : mem_m[mr];
        exp_rd = g ? (v / 16) * 16 : v;
      end
      if (wr) mem_m[ma] = cd;
      e.cv = rd; e.bz = 0;
    end
    e.cd = exp_cd; e.rd = exp_rd;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_(input int a, input int d);
    drive(0, 1, 0, a, d, 0, 0, 0);
  endtask

  task automatic rd_(input int a);
    drive(0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 100 && left > 0; i++) idle(1);
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cpu_rvalid", 8'(cpu_rvalid), e.cv);
        chk("cpu_data_o", 8'(cpu_data_o), e.cd);
        chk("ren_data_o", 8'(ren_data_o), e.rd);
        chk("busy", 8'(busy), e.bz);
      end
    end
  end

  initial begin
    foreach (mem_m[i]) mem_m[i] = 0;

    // Reset, then fill every addressable entry.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    wait_sweep();
    for (int a = 0; a < 32; a++) wr_(a, int'($urandom_range(0, 63)));

    // Mirroring
    wr_('h10, 'h2A);
    rd_('h00);
    wr_('h11, 'h15);
    rd_('h01);
    rd_('h11);

    // Read latency and back-to-back reads
    rd_('h05);
    idle(2);
    rd_('h05);
    rd_('h06);
    idle(1);

    // Collision forwarding to the render port, then write+read same address
    wr_('h03, 'h01);
    drive(0, 1, 0, 'h03, 'h30, 1, 'h03, 0);
    drive(0, 1, 0, 'h13, 'h22, 1, 'h03, 0);
    drive(0, 1, 1, 'h09, 'h11, 0, 0, 0);
    idle(1);

    // Grayscale on render only
    wr_('h07, 'h2D);
    drive(0, 0, 0, 0, 0, 1, 'h07, 1);
    drive(0, 0, 0, 0, 0, 1, 'h07, 0);
    drive(0, 0, 1, 'h07, 0, 0, 0, 1);
    idle(3);

    // Reset during RUN, then write attempt during a possible sweep
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    wr_('h05, 'h3F);
    drive(0, 0, 1, 'h05, 0, 1, 'h05, 0);
    wait_sweep();
    for (int a = 0; a < 32; a++) drive(0, 0, 1, a, 0, 1, 31 - a, 0);

    // Reset mid-sweep (or reset during RUN without the sweep)
    for (int a = 0; a < 32; a++) wr_(a, int'($urandom_range(0, 63)));
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(10);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    wait_sweep();
    for (int a = 0; a < 32; a++) rd_(a);
    for (int a = 0; a < 32; a++) wr_(a, int'($urandom_range(0, 63)));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0)
        drive(1, 0, 0, 0, 0, 0, 0, 0);
      else
        drive(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 63)), 1'($urandom), int'($urandom_range(0, 31)),
              1'($urandom));
    end
    idle(1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
